// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//   Hazard and stall sequencer for a 5-stage MIPS pipeline. It drives the load
//   enables and flushes of PC, IF/ID, ID/EX and EX/MEM. It resolves three cases:
//     - load-use hazards, with a one-cycle bubble;
//     - taken branches resolved in MEM, by flushing the three younger slots;
//     - data-memory busy, by freezing the front of the pipeline.
//   It also keeps saturating performance counters and a sticky watchdog flag
//   that fires when a freeze lasts too long.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        ID instruction actually reads rt
//   ex_memread, ex_rt load in EX and its destination register
//   mem_branch_taken  taken branch resolved in MEM
//   mem_stall         data memory busy
//   pc_write .. exmem_flush  combinational pipeline-register controls
//   freeze_timeout    sticky watchdog error
//   stall_cycles      saturating count of cycles with pc_write = 0
//   flush_events      saturating count of taken-branch flushes
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16,
  parameter int MAX_FREEZE = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             freeze_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, LOADUSE, FREEZE} state_t;

  // The freeze counter saturates at MAX_FREEZE, so it needs one extra code.
  localparam int             FW        = $clog2(MAX_FREEZE + 1);
  localparam logic [FW-1:0]  FRZ_MAX   = FW'(MAX_FREEZE);
  localparam logic [FW-1:0]  FRZ_LAST  = FW'(MAX_FREEZE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [FW-1:0]    freeze_cnt_q, freeze_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             timeout_q, timeout_d;
  logic             hz;
  logic             branch_act;

  // Register $0 is hard-wired to zero, so a load that targets it is harmless.
  assign hz = ex_memread && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Control outputs and next state. Priority: stall > branch > hazard.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    branch_act  = 1'b0;
    state_d     = RUN;
    if (reset) begin
      state_d = RUN;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = FREEZE;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      branch_act  = 1'b1;
    end else if (hz && (state_q != LOADUSE)) begin
      // In LOADUSE the bubble already sits in EX, so the hazard is resolved.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
      state_d     = LOADUSE;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = '0;
    timeout_d    = timeout_q;
    if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_act && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (mem_stall) begin
      freeze_cnt_d = (freeze_cnt_q == FRZ_MAX) ? freeze_cnt_q : freeze_cnt_q + FW'(1);
      // Fires on the edge that ends the MAX_FREEZE-th consecutive stall cycle.
      if (freeze_cnt_q >= FRZ_LAST) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      freeze_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      freeze_cnt_q <= freeze_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign freeze_timeout = timeout_q;
  assign stall_cycles   = stall_cnt_q;
  assign flush_events   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Control vector layout: {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f}
  localparam logic [6:0] RUN_V = 7'b1101010;
  localparam logic [6:0] HZ_V  = 7'b0001110;
  localparam logic [6:0] BR_V  = 7'b1111111;
  localparam logic [6:0] ST_V  = 7'b0000000;

  localparam int K_IDLE  = 0;
  localparam int K_HZ    = 1;
  localparam int K_Z     = 2;
  localparam int K_NORT  = 3;
  localparam int K_RT    = 4;
  localparam int K_BRHZ  = 5;
  localparam int K_BR    = 6;
  localparam int K_ST    = 7;
  localparam int K_STALL = 8;

  typedef struct {
    logic             rst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rt;
    logic             memread;
    logic [REG_W-1:0] ex_rt_v;
    logic             br;
    logic             stall;
    logic [6:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             to;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0, mem_stall = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush;
  logic freeze_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb_q[$];
  vec_t tbl[40];

  always #5 clk = ~clk;

  pipeline_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_FREEZE(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .freeze_timeout(freeze_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  function automatic vec_t mk(input int kind, input logic rst, input logic [6:0] ctl,
                              input int sc, input int fc, input logic to);
    vec_t v;
    v.rst = rst; v.rs = '0; v.rt = '0; v.uses_rt = 1'b0; v.memread = 1'b0;
    v.ex_rt_v = '0; v.br = 1'b0; v.stall = 1'b0;
    case (kind)
      K_HZ:    begin v.memread = 1'b1; v.ex_rt_v = 5'd2; v.rs = 5'd2; end
      K_Z:     begin v.memread = 1'b1; v.ex_rt_v = 5'd0; v.rs = 5'd0; v.uses_rt = 1'b1; end
      K_NORT:  begin v.memread = 1'b1; v.ex_rt_v = 5'd3; v.rt = 5'd3; v.rs = 5'd5; end
      K_RT:    begin v.memread = 1'b1; v.ex_rt_v = 5'd3; v.rt = 5'd3; v.rs = 5'd5; v.uses_rt = 1'b1; end
      K_BRHZ:  begin v.memread = 1'b1; v.ex_rt_v = 5'd2; v.rs = 5'd2; v.br = 1'b1; end
      K_BR:    v.br = 1'b1;
      K_ST:    v.stall = 1'b1;
      K_STALL: begin v.stall = 1'b1; v.br = 1'b1; v.memread = 1'b1; v.ex_rt_v = 5'd2; v.rs = 5'd2; end
      default: ;
    endcase
    v.ctl = ctl; v.sc = CNT_W'(sc); v.fc = CNT_W'(fc); v.to = to;
    return v;
  endfunction

  task automatic check(input string tag);
    vec_t e;
    logic [6:0] ctl_a;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard empty: got nothing, required one entry", tag);
      return;
    end
    e = sb_q.pop_front();
    ctl_a = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush};
    n_cmp++;
    if (ctl_a !== e.ctl) begin
      n_bad++;
      $display("FAIL %s ctl: got %b required %b", tag, ctl_a, e.ctl);
    end
    n_cmp++;
    if (stall_cycles !== e.sc) begin
      n_bad++;
      $display("FAIL %s stall_cycles: got %0d required %0d", tag, stall_cycles, e.sc);
    end
    n_cmp++;
    if (flush_events !== e.fc) begin
      n_bad++;
      $display("FAIL %s flush_events: got %0d required %0d", tag, flush_events, e.fc);
    end
    n_cmp++;
    if (freeze_timeout !== e.to) begin
      n_bad++;
      $display("FAIL %s freeze_timeout: got %b required %b", tag, freeze_timeout, e.to);
    end
    $display("%s: ctl=%b sc=%0d fc=%0d to=%b", tag, ctl_a, stall_cycles, flush_events, freeze_timeout);
  endtask

  // Drive one cycle of stimulus just after the edge, check at the falling edge.
  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
    ex_memread = v.memread; ex_rt = v.ex_rt_v;
    mem_branch_taken = v.br; mem_stall = v.stall;
    sb_q.push_back(v);
    @(negedge clk);
    check(tag);
  endtask

  int hsc;
  int hstep;

  initial begin
    tbl[0]  = mk(K_IDLE,  1'b1, RUN_V, 0, 0, 1'b0);
    tbl[1]  = mk(K_IDLE,  1'b0, RUN_V, 0, 0, 1'b0);
    tbl[2]  = mk(K_HZ,    1'b0, HZ_V,  0, 0, 1'b0);
    tbl[3]  = mk(K_HZ,    1'b0, RUN_V, 1, 0, 1'b0);
    tbl[4]  = mk(K_HZ,    1'b0, HZ_V,  1, 0, 1'b0);
    tbl[5]  = mk(K_IDLE,  1'b0, RUN_V, 2, 0, 1'b0);
    tbl[6]  = mk(K_Z,     1'b0, RUN_V, 2, 0, 1'b0);
    tbl[7]  = mk(K_NORT,  1'b0, RUN_V, 2, 0, 1'b0);
    tbl[8]  = mk(K_RT,    1'b0, HZ_V,  2, 0, 1'b0);
    tbl[9]  = mk(K_IDLE,  1'b0, RUN_V, 3, 0, 1'b0);
    tbl[10] = mk(K_BRHZ,  1'b0, BR_V,  3, 0, 1'b0);
    tbl[11] = mk(K_IDLE,  1'b0, RUN_V, 3, 1, 1'b0);
    tbl[12] = mk(K_HZ,    1'b0, HZ_V,  3, 1, 1'b0);
    tbl[13] = mk(K_BR,    1'b0, BR_V,  4, 1, 1'b0);
    tbl[14] = mk(K_IDLE,  1'b0, RUN_V, 4, 2, 1'b0);
    tbl[15] = mk(K_STALL, 1'b0, ST_V,  4, 2, 1'b0);
    tbl[16] = mk(K_ST,    1'b0, ST_V,  5, 2, 1'b0);
    tbl[17] = mk(K_ST,    1'b0, ST_V,  6, 2, 1'b0);
    tbl[18] = mk(K_HZ,    1'b0, HZ_V,  7, 2, 1'b0);
    tbl[19] = mk(K_IDLE,  1'b0, RUN_V, 8, 2, 1'b0);
    tbl[20] = mk(K_ST,    1'b0, ST_V,  8, 2, 1'b0);
    tbl[21] = mk(K_ST,    1'b0, ST_V,  9, 2, 1'b0);
    tbl[22] = mk(K_ST,    1'b0, ST_V, 10, 2, 1'b0);
    tbl[23] = mk(K_ST,    1'b0, ST_V, 11, 2, 1'b0);
    tbl[24] = mk(K_ST,    1'b0, ST_V, 12, 2, 1'b1);
    tbl[25] = mk(K_ST,    1'b0, ST_V, 13, 2, 1'b1);
    tbl[26] = mk(K_BR,    1'b0, BR_V, 14, 2, 1'b1);
    tbl[27] = mk(K_IDLE,  1'b0, RUN_V, 14, 3, 1'b1);
    tbl[28] = mk(K_HZ,    1'b0, HZ_V, 14, 3, 1'b1);
    tbl[29] = mk(K_IDLE,  1'b0, RUN_V, 15, 3, 1'b1);
    tbl[30] = mk(K_HZ,    1'b0, HZ_V, 15, 3, 1'b1);
    tbl[31] = mk(K_ST,    1'b0, ST_V, 15, 3, 1'b1);
    tbl[32] = mk(K_ST,    1'b0, ST_V, 15, 3, 1'b1);
    tbl[33] = mk(K_ST,    1'b1, RUN_V, 0, 0, 1'b0);
    tbl[34] = mk(K_HZ,    1'b0, HZ_V,  0, 0, 1'b0);
    tbl[35] = mk(K_IDLE,  1'b0, RUN_V, 1, 0, 1'b0);
    tbl[36] = mk(K_HZ,    1'b0, HZ_V,  1, 0, 1'b0);
    tbl[37] = mk(K_HZ,    1'b1, RUN_V, 0, 0, 1'b0);
    tbl[38] = mk(K_HZ,    1'b0, HZ_V,  0, 0, 1'b0);
    tbl[39] = mk(K_IDLE,  1'b0, RUN_V, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // Watchdog: a single released cycle between freezes restarts the count,
    // so 3+3 stalls do not fire, while 4 consecutive ones do.
    hsc = 1;
    for (int b = 0; b < 3; b++) begin
      hstep = (b == 2) ? 4 : 3;
      for (int j = 0; j < hstep; j++) begin
        step(mk(K_ST, 1'b0, ST_V, hsc, 0, 1'b0), $sformatf("wd_b%0d_s%0d", b, j));
        hsc++;
      end
      if (b < 2) step(mk(K_IDLE, 1'b0, RUN_V, hsc, 0, 1'b0), $sformatf("wd_b%0d_rel", b));
    end
    step(mk(K_IDLE, 1'b0, RUN_V, hsc, 0, 1'b1), "wd_fired");

    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Hazard and stall sequencer for the 5-stage MIPS pipeline. It sits beside the opcode decoder and drives the write enables and flushes of PC, IF/ID, ID/EX and EX/MEM. It resolves three conditions:
- load-use hazards, by inserting a one-cycle bubble;
- taken branches resolved in MEM, by flushing the three younger instructions;
- data-memory busy, by freezing the whole front of the pipeline.

It also keeps saturating performance counters and a freeze-watchdog error flag.

## Interface
Parameters:
- REG_W, 5, register-address width
- CNT_W, 16, width of the performance counters
- MAX_FREEZE, 64, freeze cycles before the watchdog fires (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, BEQ, BNE, SW)
- ex_memread  in  1  MemRead of the instruction in EX (LW)
- ex_rt  in  REG_W  destination rt of the instruction in EX
- mem_branch_taken  in  1  Branch & condition-met in MEM
- mem_stall  in  1  data memory busy; the MEM access is not complete
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to bubble (all control bits 0)
- exmem_write  out  1  EX/MEM load enable
- exmem_flush  out  1  EX/MEM clear to bubble
- freeze_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  cycles with pc_write=0, saturating
- flush_events  out  CNT_W  taken-branch flushes, saturating

## Operation
FSM states: RUN, LOADUSE, FREEZE. Control outputs are combinational from the state and the inputs. The FSM, counters and flag are registered.

Hazard detection:
- hz = ex_memread & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Register $0 never causes a hazard.

Priority each cycle: mem_stall > mem_branch_taken > hz.

- **mem_stall=1 (any state):**
  - pc_write, ifid_write, idex_write and exmem_write are 0; all flushes are 0.
  - Next state is FREEZE.
  - A pending branch or hazard is not acted on until the stall releases.
- **mem_branch_taken (mem_stall=0, any state):**
  - pc_write=1 (target load).
  - ifid_flush, idex_flush and exmem_flush are 1; all writes are 1.
  - flush_events increments. Next state is RUN.
- **hz in RUN or FREEZE (no stall, no branch):**
  - pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1.
  - Next state is LOADUSE.
- **LOADUSE:**
  - hz is ignored, because EX holds the bubble.
  - Writes are all 1 and flushes are 0, unless stall or branch applies.
  - Next state is RUN.
- **Otherwise:** all writes 1, all flushes 0. Next state is RUN.

FREEZE with mem_stall=0 evaluates exactly like RUN in the same cycle. There is no extra recovery cycle.

Counters and watchdog:
- A freeze counter counts consecutive mem_stall cycles.
- If it reaches MAX_FREEZE, freeze_timeout sets and holds until reset. The pipeline keeps obeying mem_stall.
- The freeze counter clears on any cycle with mem_stall=0.
- stall_cycles and flush_events saturate at 2^CNT_W−1.

## Timing
- Reset (async): state=RUN, counters=0, freeze_timeout=0.
- While reset is asserted, outputs are the RUN/no-hazard values: writes 1, flushes 0.
- Reset mid-FREEZE or mid-LOADUSE aborts that sequence immediately.
- Zero-cycle latency from inputs to control outputs.
- Counter and flag updates are visible the cycle after the causing event.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 3 flushed slots and 0 stall cycles.
- A freeze of N cycles adds N to stall_cycles.
- If a branch and a hazard occur together, only the branch acts: no bubble, no stall count.
- freeze_timeout asserts on the edge ending the MAX_FREEZE-th consecutive stall cycle.

## Test plan
- LW $2 in EX (ex_memread=1, ex_rt=2), ID rs=2 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1. Next cycle (LOADUSE) all writes are 1. stall_cycles=1.
- ex_rt=0 with id_rs=0, ex_memread=1 -> no stall. Also id_uses_rt=0 with id_rt==ex_rt -> no stall.
- mem_branch_taken=1 concurrent with hz -> three flushes and pc_write=1 that cycle. flush_events=1, stall_cycles=0. Next state is RUN.
- mem_stall high for 5 cycles, then hz on the release cycle -> all writes 0 for 5 cycles, then a bubble on release. stall_cycles=6.
- MAX_FREEZE=4, mem_stall high for 6 cycles -> freeze_timeout rises after the 4th cycle and stays 1 after mem_stall drops.
- Assert reset during FREEZE with counters nonzero -> writes return to 1 immediately. Counters and flag are 0; state is RUN.
